// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing one FIFO write port
//
// Purpose:
//   Grants one of NREQ valid/ready requesters at a time for bursts of up to
//   MAX_BURST words and forwards the owner's words to the FIFO write port,
//   throttled by the FIFO full flag. Release hands over to the next valid
//   requester in the same cycle, so consecutive owners see no bubble.
//
// Ports:
//   clk_i        clock
//   arst_n_i     asynchronous active-low reset
//   req_valid_i  per-requester word valid
//   req_data_i   requester k data at [k*DWIDTH +: DWIDTH]
//   req_ready_o  per-requester accept (at most one bit high)
//   full_i       FIFO full flag
//   wrreq_o      FIFO write request
//   data_o       FIFO write data (meaningful only while wrreq_o is high)
//   grant_o      one-hot current owner, zero when idle
//   busy_o       high while a requester owns the port
module fifo_wr_arbiter #(
  parameter int DWIDTH    = 64,
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 8
) (
  input  logic                     clk_i,
  input  logic                     arst_n_i,
  input  logic [NREQ-1:0]          req_valid_i,
  input  logic [NREQ*DWIDTH-1:0]   req_data_i,
  output logic [NREQ-1:0]          req_ready_o,
  input  logic                     full_i,
  output logic                     wrreq_o,
  output logic [DWIDTH-1:0]        data_o,
  output logic [NREQ-1:0]          grant_o,
  output logic                     busy_o
);

  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int PW = $clog2(NREQ);
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);
  localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);
  localparam logic [PW:0]   NREQ_W   = (PW+1)'(NREQ);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   burst_cnt_q, burst_cnt_d;
  logic [NREQ-1:0] grant_q, grant_d;

  logic [PW-1:0]   owner_next;
  logic [PW-1:0]   search_base;
  logic [PW-1:0]   win_idx;
  logic [NREQ-1:0] win_onehot;
  logic            win_found;
  logic            owner_valid;
  logic            xfer;
  logic            release_grant;

  assign owner_next  = (owner_q == LAST_IDX) ? '0 : owner_q + PW'(1);
  assign owner_valid = req_valid_i[owner_q];

  // While granted, the only search that matters is the hand-over search,
  // which starts just after the current owner so it ends up lowest priority.
  assign search_base = (state_q == S_GRANT) ? owner_next : rr_ptr_q;

  always_comb begin
    logic [PW:0] pos;
    win_found = 1'b0;
    win_idx   = '0;
    pos       = '0;
    for (int i = 0; i < NREQ; i++) begin
      pos = {1'b0, search_base} + (PW+1)'(i);
      if (pos >= NREQ_W) pos = pos - NREQ_W;
      if (!win_found && req_valid_i[pos[PW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = pos[PW-1:0];
      end
    end
  end

  assign win_onehot = NREQ'(1) << win_idx;

  always_comb begin
    req_ready_o = '0;
    wrreq_o     = 1'b0;
    if (state_q == S_GRANT) begin
      req_ready_o[owner_q] = ~full_i;
      wrreq_o              = owner_valid & ~full_i;
    end
  end

  assign data_o  = req_data_i[int'(owner_q)*DWIDTH +: DWIDTH];
  assign grant_o = grant_q;
  assign busy_o  = (state_q == S_GRANT);
  assign xfer    = wrreq_o;

  // A full FIFO at the burst limit blocks xfer, so the last word must really
  // be written before the grant moves on.
  assign release_grant = (xfer && (burst_cnt_q == LAST_CNT)) || !owner_valid;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    grant_d     = grant_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d     = S_GRANT;
          owner_d     = win_idx;
          burst_cnt_d = '0;
          grant_d     = win_onehot;
        end
      end
      S_GRANT: begin
        if (release_grant) begin
          rr_ptr_d    = owner_next;
          burst_cnt_d = '0;
          if (win_found) begin
            owner_d = win_idx;
            grant_d = win_onehot;
          end else begin
            state_d = S_IDLE;
            grant_d = '0;
          end
        end else if (xfer) begin
          burst_cnt_d = burst_cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q     <= S_IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      grant_q     <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      grant_q     <= grant_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
  localparam int DW = 64;
  localparam int N  = 4;
  localparam int MB = 8;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic            arst_n_i;
  logic [N-1:0]    req_valid_i;
  logic [N*DW-1:0] req_data_i;
  logic [N-1:0]    req_ready_o;
  logic            full_i;
  logic            wrreq_o;
  logic [DW-1:0]   data_o;
  logic [N-1:0]    grant_o;
  logic            busy_o;

  logic [N-1:0]    v1;
  logic [N*DW-1:0] d1;
  logic [N-1:0]    ready1;
  logic            full1;
  logic            wr1;
  logic [DW-1:0]   data1;
  logic [N-1:0]    g1;
  logic            b1;

  fifo_wr_arbiter #(.DWIDTH(DW), .NREQ(N), .MAX_BURST(MB)) dut (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .req_valid_i(req_valid_i),
    .req_data_i(req_data_i), .req_ready_o(req_ready_o), .full_i(full_i),
    .wrreq_o(wrreq_o), .data_o(data_o), .grant_o(grant_o), .busy_o(busy_o)
  );

  fifo_wr_arbiter #(.DWIDTH(DW), .NREQ(N), .MAX_BURST(1)) dut1 (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .req_valid_i(v1),
    .req_data_i(d1), .req_ready_o(ready1), .full_i(full1),
    .wrreq_o(wr1), .data_o(data1), .grant_o(g1), .busy_o(b1)
  );

  int errors = 0;
  int checks = 0;

  // requester stimulus state
  int rem [N];
  int seq [N];
  int tot [N];
  int gap_pct, full_pct, full_force;

  // reference model: owner (-1 = idle), words in current burst, priority start
  int m_owner, m_cnt, m_ptr;

  int wr_log[$];
  int run, max_run, stall_cnt;
  logic [N-1:0] last_grant;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] word(input int k, input int s);
    return {32'(k), 32'(s)};
  endfunction

  function automatic int pick(input logic [N-1:0] v, input int start);
    for (int i = 0; i < N; i++) begin
      if (v[(start + i) % N]) return (start + i) % N;
    end
    return -1;
  endfunction

  function automatic bit pending();
    for (int k = 0; k < N; k++) if (rem[k] > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic refill();
    for (int k = 0; k < N; k++) begin
      if (!req_valid_i[k] && rem[k] > 0 && $urandom_range(99) >= gap_pct) begin
        req_valid_i[k] = 1'b1;
        req_data_i[k*DW +: DW] = word(k, seq[k]);
      end
    end
  endtask

  task automatic cycle();
    logic [N-1:0]  eg, er;
    logic          ew, eb;
    logic [DW-1:0] ed;
    int            xk;
    @(negedge clk_i);
    eg = '0; er = '0; ew = 1'b0; eb = 1'b0; ed = '0;
    if (m_owner >= 0) begin
      eb = 1'b1;
      eg[m_owner] = 1'b1;
      if (!full_i) er[m_owner] = 1'b1;
      ew = req_valid_i[m_owner] && !full_i;
      ed = word(m_owner, seq[m_owner]);
    end
    chk("grant", grant_o, eg);
    chk("ready", req_ready_o, er);
    chk("wrreq", wrreq_o, ew);
    chk("busy", busy_o, eb);
    if (ew) chk("data", data_o, ed);
    last_grant = grant_o;
    if (wrreq_o === 1'b1) begin
      run++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
    if (busy_o === 1'b1 && wrreq_o === 1'b0 && req_ready_o === '0) stall_cnt++;
    xk = ew ? m_owner : -1;
    if (m_owner < 0) begin
      m_owner = pick(req_valid_i, m_ptr);
      m_cnt   = 0;
    end else begin
      if (ew) m_cnt++;
      if ((ew && m_cnt == MB) || !req_valid_i[m_owner]) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = pick(req_valid_i, m_ptr);
        m_cnt   = 0;
      end
    end
    @(posedge clk_i);
    #1;
    if (xk >= 0) begin
      wr_log.push_back(xk);
      seq[xk]++;
      rem[xk]--;
      req_valid_i[xk] = 1'b0;
    end
    if (full_force > 0) begin
      full_i = 1'b1;
      full_force--;
    end else begin
      full_i = ($urandom_range(99) < full_pct);
    end
    refill();
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((pending() || m_owner >= 0) && n < limit) begin
      cycle();
      n++;
    end
    checks++;
    assert (n < limit) else begin
      errors++;
      $error("FAIL drain_timeout cycles=%0d limit=%0d", n, limit);
    end
  endtask

  task automatic do_reset();
    arst_n_i    = 1'b0;
    req_valid_i = '0;
    req_data_i  = '0;
    full_i      = 1'b0;
    full_force  = 0;
    v1 = '0; d1 = '0; full1 = 1'b0;
    m_owner = -1; m_ptr = 0; m_cnt = 0;
    wr_log.delete();
    run = 0; max_run = 0; stall_cnt = 0;
    gap_pct = 0; full_pct = 0;
    for (int k = 0; k < N; k++) begin
      rem[k] = 0; seq[k] = 0; tot[k] = 0;
    end
    #1;
    chk("rst_grant", grant_o, '0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_wrreq", wrreq_o, 1'b0);
    chk("rst_ready", req_ready_o, '0);
    @(posedge clk_i);
    #2;
    arst_n_i = 1'b1;
  endtask

  initial begin
    int n, lead, o;
    logic [N-1:0] oh;
    int s1 [N];

    arst_n_i = 1'b1;
    req_valid_i = '0; req_data_i = '0; full_i = 1'b0;
    v1 = '0; d1 = '0; full1 = 1'b0;
    #3;

    // single stream: requester 1, 10 words
    do_reset();
    rem[1] = 10;
    refill();
    cycle();
    cycle();
    chk("ss_grant", last_grant, 4'b0010);
    drain(200);
    chk("ss_run", max_run, 10);
    chk("ss_words", wr_log.size(), 10);

    // round robin: all continuously valid
    do_reset();
    for (int k = 0; k < N; k++) rem[k] = 16;
    refill();
    drain(400);
    chk("rr_run", max_run, 64);
    for (int i = 0; i < 64; i++) chk("rr_owner", wr_log[i], (i / 8) % 4);

    // full stall for 3 cycles after requester 0's 3rd word
    do_reset();
    rem[0] = 12; rem[1] = 4;
    refill();
    n = 0;
    while (seq[0] < 3 && n < 100) begin
      cycle();
      n++;
    end
    full_i = 1'b1;
    full_force = 2;
    drain(200);
    chk("fs_stalls", stall_cnt, 3);
    lead = 0;
    while (lead < wr_log.size() && wr_log[lead] == 0) lead++;
    chk("fs_burst", lead, 8);
    chk("fs_words", wr_log.size(), 16);
    chk("fs_next", wr_log[8], 1);

    // early finish: requester 2 sends 3 words, requester 3 waiting
    do_reset();
    rem[2] = 3; rem[3] = 5;
    refill();
    drain(200);
    chk("ef_words", wr_log.size(), 8);
    chk("ef_first", wr_log[0], 2);
    chk("ef_handover", wr_log[3], 3);
    @(negedge clk_i);
    chk("ef_idle", busy_o, 1'b0);

    // reset in the middle of owner 2's burst
    do_reset();
    rem[2] = 10;
    refill();
    n = 0;
    while (seq[2] < 4 && n < 100) begin
      cycle();
      n++;
    end
    arst_n_i = 1'b0;
    #1;
    chk("mr_wrreq", wrreq_o, 1'b0);
    chk("mr_ready", req_ready_o, '0);
    chk("mr_grant", grant_o, '0);
    chk("mr_busy", busy_o, 1'b0);
    m_owner = -1; m_ptr = 0; m_cnt = 0;
    wr_log.delete();
    for (int k = 0; k < N; k++) if (rem[k] < 3) rem[k] = 3;
    refill();
    @(posedge clk_i);
    #2;
    arst_n_i = 1'b1;
    drain(300);
    chk("mr_first", wr_log[0], 0);
    chk("mr_req2_total", seq[2], 10);

    // randomized traffic with gaps and backpressure
    do_reset();
    gap_pct = 30; full_pct = 25;
    for (int k = 0; k < N; k++) begin
      rem[k] = $urandom_range(30, 5);
      tot[k] = rem[k];
    end
    refill();
    drain(3000);
    for (int k = 0; k < N; k++) chk("rnd_total", seq[k], tot[k]);

    // MAX_BURST=1: grant rotates every word
    do_reset();
    for (int k = 0; k < N; k++) begin
      s1[k] = 0;
      d1[k*DW +: DW] = word(k, 0);
    end
    v1 = '1;
    o = 0;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk_i);
      if (i == 0) begin
        chk("mb1_idle", g1, '0);
      end else begin
        o = (i - 1) % N;
        oh = '0;
        oh[o] = 1'b1;
        chk("mb1_grant", g1, oh);
        chk("mb1_ready", ready1, oh);
        chk("mb1_busy", b1, 1'b1);
        chk("mb1_wrreq", wr1, 1'b1);
        chk("mb1_data", data1, word(o, s1[o]));
      end
      @(posedge clk_i);
      #1;
      if (i > 0) begin
        s1[o]++;
        d1[o*DW +: DW] = word(o, s1[o]);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin arbiter that shares a single FIFO write port among NREQ requesters. Each requester has a valid/ready stream interface. The block grants one requester at a time for bursts of up to MAX_BURST words, forwards its data to the FIFO write port, and applies backpressure from the FIFO full flag. It sits directly in front of the FIFO's data/wrreq inputs.

Parameters:
DWIDTH, 64, data word width; must match the FIFO DWIDTH.
NREQ, 4, number of requesters; 2..16.
MAX_BURST, 8, maximum consecutive words per grant; >=1. Burst counter width is max(1, $clog2(MAX_BURST)).

Ports:
clk_i  in  1  clock.
arst_n_i  in  1  asynchronous active-low reset.
req_valid_i  in  NREQ  per-requester word valid.
req_data_i  in  NREQ*DWIDTH  requester k data occupies bits [k*DWIDTH +: DWIDTH].
req_ready_o  out  NREQ  per-requester accept; at most one bit high.
full_i  in  1  FIFO full flag.
wrreq_o  out  1  FIFO write request.
data_o  out  DWIDTH  FIFO write data.
grant_o  out  NREQ  one-hot current owner; all zero when idle.
busy_o  out  1  high when in GRANT state.

Behaviour:
- Reset (async assert, sync deassert handled upstream): state=IDLE, grant_o=0, busy_o=0, burst_cnt=0, rr_ptr=0 (requester 0 has highest priority). req_ready_o=0 and wrreq_o=0, because both are combinational from the state. data_o is don't-care while wrreq_o=0.
- Requester rule: once valid is asserted, it is held with stable data until ready is seen (transfer). Valid may drop only after a transfer.
- Priority search: the winner is the first valid requester scanning rr_ptr, rr_ptr+1, ... mod NREQ.
- IDLE: if any req_valid_i is set, register the winner into grant_o and go to GRANT next cycle with burst_cnt=0. This gives 1 cycle arbitration latency from idle. No ready or write is issued in IDLE.
- GRANT, owner k (all combinational):
  - req_ready_o[k] = ~full_i; all other ready bits are 0.
  - wrreq_o = req_valid_i[k] & ~full_i.
  - data_o = requester k data.
  - Transfer = wrreq_o.
- Burst counting: on each transfer burst_cnt increments. While full_i is high, nothing transfers and grant and burst_cnt hold.
- Release conditions:
  - (a) a transfer with burst_cnt==MAX_BURST-1;
  - (b) req_valid_i[k]==0, meaning the owner has finished.
- On release, rr_ptr <= (k+1) mod NREQ. The next owner is chosen the same cycle from the current req_valid_i, with k at lowest priority.
  - If a winner exists: stay in GRANT with the new owner and burst_cnt=0, so there is no bubble between owners.
  - Otherwise go to IDLE and set grant_o=0.
- Sole requester: on release by (a), the same k is re-granted if it is the only valid requester, so a continuous stream continues with no gap.
- Full at burst limit: if full_i is high when burst_cnt==MAX_BURST-1, no release occurs until that word actually transfers.
- Async reset mid-burst: all state clears immediately. Any word not yet transferred remains the requester's responsibility.
- Ordering and loss: words are never duplicated or dropped. FIFO write order per requester equals issue order.

Test Plan:
- Single stream: requester 1 streams 10 words, MAX_BURST=8, full_i=0 -> grant_o=0010 one cycle after the first valid. wrreq_o is high for 10 consecutive cycles, data is in order, and there is no gap at the word-8 re-grant.
- Round-robin: all 4 requesters continuously valid -> owners 0,1,2,3,0 with exactly 8 words each and zero idle cycles between owners. rr_ptr cycles 1,2,3,0.
- Full stall: full_i high for 3 cycles after requester 0's 3rd word -> wrreq_o and req_ready_o are 0 for 3 cycles, grant_o and burst_cnt are held, the burst then completes with 8 total words, and no word is lost.
- Early finish: requester 2 sends 3 words then drops valid, with requester 3 valid -> grant_o=1000 on the cycle after the drop and requester 3's first word is written in that cycle. If no other requester is valid -> IDLE and busy_o=0.
- Reset mid-burst: assert arst_n_i low after 4 words of owner 2 -> wrreq_o, req_ready_o, grant_o and busy_o go to 0 immediately. After release with all requesters valid, requester 0 is granted first.
- MAX_BURST=1: with all valid, the grant rotates every transfer (0,1,2,3,...) and each owner writes one word per grant.
